// File: rtl/sal_inter_bank_sched_pkg.sv
// sal_sched_pkg: command encoding, priorities and default field widths for the inter-bank scheduler.
// Width macros fall back to defaults here when the controller build does not supply them.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 2
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 5
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 5
`endif

package sal_sched_pkg;

    typedef enum logic [2:0] {NOP = 3'd0, ACT, RD, WR, PRE, REF} sched_cmd_t;

    localparam int PRIO_WR  = 0;
    localparam int PRIO_RD  = 1;
    localparam int PRIO_ACT = 2;
    localparam int PRIO_PRE = 3;
    localparam int PRIO_REF = 4;

    // Later assignments override earlier ones, so the highest priority wins.
    function automatic sched_cmd_t resolve(input logic ref_r, input logic pre_r, input logic act_r,
                                           input logic rd_r, input logic wr_r);
        logic [4:0] r;
        sched_cmd_t c;
        r = '0;
        r[PRIO_REF] = ref_r;
        r[PRIO_PRE] = pre_r;
        r[PRIO_ACT] = act_r;
        r[PRIO_RD]  = rd_r;
        r[PRIO_WR]  = wr_r;
        c = NOP;
        if (r[PRIO_WR])  c = WR;
        if (r[PRIO_RD])  c = RD;
        if (r[PRIO_ACT]) c = ACT;
        if (r[PRIO_PRE]) c = PRE;
        if (r[PRIO_REF]) c = REF;
        return c;
    endfunction

endpackage

// File: rtl/sal_inter_bank_sched_if.sv
// sal_inter_bank_sched_if: bank-controller request/grant bundle plus the registered command toward the DFI encoder.
interface sal_inter_bank_sched_if
#(
    parameter int NB = 4
) ();
    import sal_sched_pkg::*;

    logic [NB-1:0]                     act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NB-1:0][`DRAM_RA_WIDTH-1:0] ra_i;
    logic [NB-1:0][`DRAM_CA_WIDTH-1:0] ca_i;
    logic [NB-1:0][`AXI_ID_WIDTH-1:0]  id_i;
    logic [NB-1:0][`AXI_LEN_WIDTH-1:0] len_i;
    logic [NB-1:0]                     act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic                              cmd_valid;
    sched_cmd_t                        cmd_type;
    logic [`DRAM_BA_WIDTH-1:0]         cmd_ba;
    logic [`DRAM_RA_WIDTH-1:0]         cmd_ra;
    logic [`DRAM_CA_WIDTH-1:0]         cmd_ca;
    logic [`AXI_ID_WIDTH-1:0]          cmd_id;
    logic [`AXI_LEN_WIDTH-1:0]         cmd_len;

    modport master (
        output act_req, rd_req, wr_req, pre_req, ref_req, ra_i, ca_i, id_i, len_i,
        input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        input  cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
    );

    modport slave (
        input  act_req, rd_req, wr_req, pre_req, ref_req, ra_i, ca_i, id_i, len_i,
        output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        output cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
    );

endinterface

// File: rtl/sal_inter_bank_sched_rr_arbiter.sv
// sal_rr_arbiter: one-hot rotating-priority pick, searching upward from ptr with wraparound.
module sal_rr_arbiter
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    // Scan from the farthest offset down so the nearest requester to ptr is the final assignment.
    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) gnt = N'(1) << ((int'(ptr) + i) % N);
    end

endmodule

// File: rtl/sal_inter_bank_sched.sv
// sal_inter_bank_sched: grants one bank command per cycle under tRRD/tCCD/tWTR/tRTW and registers it downstream.
// Define SAL_SCHED_CAS_FIRST_EN to favour eligible RD/WR over ACT/PRE (REF still first).
module sal_inter_bank_sched
    import sal_sched_pkg::*;
#(
    parameter int NUM_BANKS = 1 << `DRAM_BA_WIDTH
) (
    input logic                    clk,
    input logic                    rst,
    sal_inter_bank_sched_if.slave  bus,
    input logic [`T_RRD_WIDTH-1:0] t_rrd_m1,
    input logic [`T_CCD_WIDTH-1:0] t_ccd_m1,
    input logic [`T_WTR_WIDTH-1:0] t_wtr_m1,
    input logic [`T_RTW_WIDTH-1:0] t_rtw_m1
);

    localparam int BW    = `DRAM_BA_WIDTH;
    localparam int RRD_W = `T_RRD_WIDTH;
    localparam int CCD_W = `T_CCD_WIDTH;
    localparam int WTR_W = `T_WTR_WIDTH;
    localparam int RTW_W = `T_RTW_WIDTH;

    sched_cmd_t           cand [NUM_BANKS];
    sched_cmd_t           gcmd;
    logic [NUM_BANKS-1:0] elig, pick, gnt, act_g, rd_g, wr_g, pre_g, ref_g;
    logic [BW-1:0]        rr_ptr, gb;
    logic                 any_gnt;
    logic [RRD_W-1:0]     rrd_cnt;
    logic [CCD_W-1:0]     ccd_cnt;
    logic [WTR_W-1:0]     wtr_cnt;
    logic [RTW_W-1:0]     rtw_cnt;

    always_comb begin
        cand = '{default: NOP};
        elig = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            cand[b] = resolve(bus.ref_req[b], bus.pre_req[b], bus.act_req[b], bus.rd_req[b], bus.wr_req[b]);
            elig[b] = cand[b] == PRE || cand[b] == REF
                   || (cand[b] == ACT && rrd_cnt == '0)
                   || (cand[b] == RD && ccd_cnt == '0 && wtr_cnt == '0)
                   || (cand[b] == WR && ccd_cnt == '0 && rtw_cnt == '0);
        end
    end

`ifdef SAL_SCHED_CAS_FIRST_EN
    logic [NUM_BANKS-1:0] cas_c, ref_c, oth_c, gnt_cas, gnt_oth;

    always_comb begin
        cas_c = '0;
        ref_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            cas_c[b] = elig[b] && (cand[b] == RD || cand[b] == WR);
            ref_c[b] = elig[b] && cand[b] == REF;
        end
    end

    assign oth_c = |ref_c ? ref_c : elig & ~cas_c;

    sal_rr_arbiter #(.N(NUM_BANKS)) u_arb_cas (.req(cas_c), .ptr(rr_ptr), .gnt(gnt_cas));
    sal_rr_arbiter #(.N(NUM_BANKS)) u_arb_oth (.req(oth_c), .ptr(rr_ptr), .gnt(gnt_oth));

    assign pick = (|cas_c && !(|ref_c)) ? gnt_cas : gnt_oth;
`else
    sal_rr_arbiter #(.N(NUM_BANKS)) u_arb (.req(elig), .ptr(rr_ptr), .gnt(pick));
`endif

    assign gnt     = rst ? '0 : pick;
    assign any_gnt = |gnt;

    always_comb begin
        gb    = '0;
        act_g = '0;
        rd_g  = '0;
        wr_g  = '0;
        pre_g = '0;
        ref_g = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt[b]) gb = BW'(b);
            act_g[b] = gnt[b] && cand[b] == ACT;
            rd_g[b]  = gnt[b] && cand[b] == RD;
            wr_g[b]  = gnt[b] && cand[b] == WR;
            pre_g[b] = gnt[b] && cand[b] == PRE;
            ref_g[b] = gnt[b] && cand[b] == REF;
        end
    end

    assign gcmd        = any_gnt ? cand[gb] : NOP;
    assign bus.act_gnt = act_g;
    assign bus.rd_gnt  = rd_g;
    assign bus.wr_gnt  = wr_g;
    assign bus.pre_gnt = pre_g;
    assign bus.ref_gnt = ref_g;

    // Loads win over the decrement; eligibility above sees only these registered values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            rrd_cnt       <= '0;
            ccd_cnt       <= '0;
            wtr_cnt       <= '0;
            rtw_cnt       <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_type  <= NOP;
            bus.cmd_ba    <= '0;
            bus.cmd_ra    <= '0;
            bus.cmd_ca    <= '0;
            bus.cmd_id    <= '0;
            bus.cmd_len   <= '0;
        end else begin
            if (any_gnt) begin
                rr_ptr      <= gb + BW'(1);
                bus.cmd_ba  <= gb;
                bus.cmd_ra  <= bus.ra_i[gb];
                bus.cmd_ca  <= bus.ca_i[gb];
                bus.cmd_id  <= bus.id_i[gb];
                bus.cmd_len <= bus.len_i[gb];
            end
            bus.cmd_valid <= any_gnt;
            bus.cmd_type  <= gcmd;
            rrd_cnt <= gcmd == ACT ? t_rrd_m1 : rrd_cnt != '0 ? rrd_cnt - RRD_W'(1) : rrd_cnt;
            ccd_cnt <= (gcmd == RD || gcmd == WR) ? t_ccd_m1 : ccd_cnt != '0 ? ccd_cnt - CCD_W'(1) : ccd_cnt;
            wtr_cnt <= gcmd == WR ? t_wtr_m1 : wtr_cnt != '0 ? wtr_cnt - WTR_W'(1) : wtr_cnt;
            rtw_cnt <= gcmd == RD ? t_rtw_m1 : rtw_cnt != '0 ? rtw_cnt - RTW_W'(1) : rtw_cnt;
        end
    end

endmodule

// File: doc/sal_inter_bank_sched.md
# sal_inter_bank_sched

Inter-bank command scheduler for the DRAM controller. It collects per-bank command requests (act/rd/wr/pre/ref) from NUM_BANKS bank controllers over the scheduler request/grant protocol and grants at most one command per cycle. Grants respect the inter-bank timing constraints tRRD, tCCD, tWTR and tRTW, taken from the timing register block. It sits between the bank controllers and the DFI command encoder, and drives one registered command per cycle downstream.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- NUM_BANKS, default 4: number of bank-controller requesters. Must be 2^`DRAM_BA_WIDTH.

Ports (per-bank vectors are indexed by bank number):
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- act_req/rd_req/wr_req/pre_req/ref_req  input  [NUM_BANKS]  per-bank requests
- ra_i  input  [NUM_BANKS][`DRAM_RA_WIDTH]  per-bank row address
- ca_i  input  [NUM_BANKS][`DRAM_CA_WIDTH]  per-bank column address
- id_i  input  [NUM_BANKS][`AXI_ID_WIDTH]  per-bank AXI ID
- len_i  input  [NUM_BANKS][`AXI_LEN_WIDTH]  per-bank AXI length
- act_gnt/rd_gnt/wr_gnt/pre_gnt/ref_gnt  output  [NUM_BANKS]  combinational grants
- t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  input  `T_*_WIDTH  timing values, stable during operation
- cmd_valid  output  1  registered command valid
- cmd_type  output  sched_cmd_t  NOP/ACT/RD/WR/PRE/REF
- cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len  output  matching widths  registered command fields

## Operation
- Request resolution within one bank: when a bank asserts several requests at once, it is resolved by fixed priority REF > PRE > ACT > RD > WR. Only one candidate is produced per bank.
- Eligibility:
  - PRE and REF: always eligible.
  - ACT: eligible only when rrd_cnt==0.
  - RD: eligible only when ccd_cnt==0 and wtr_cnt==0.
  - WR: eligible only when ccd_cnt==0 and rtw_cnt==0.
- Arbitration:
  - Round-robin over eligible bank candidates, starting at rr_ptr.
  - Exactly zero or one gnt bit is asserted across all grant vectors per cycle.
  - Grants are combinational in the same cycle as the request.
  - A bank holds its request until it is granted and drops it the cycle after.
- On a grant:
  - rr_ptr <= granted bank + 1, mod NUM_BANKS. When there is no grant, rr_ptr holds.
  - The command fields are registered into the cmd_* outputs.
- Timers: 4 down-counters that saturate at 0.
  - ACT grant loads rrd_cnt with t_rrd_m1.
  - RD or WR grant loads ccd_cnt with t_ccd_m1.
  - WR grant loads wtr_cnt with t_wtr_m1. Software programs t_wtr_m1 to include write latency plus burst.
  - RD grant loads rtw_cnt with t_rtw_m1.
  - A load takes priority over a decrement in the same cycle.
  - Counters that are not loaded decrement when nonzero.
- Widths: each counter uses its `T_*_WIDTH`. A value of m1=0 means a back-to-back command is allowed on the next cycle.

## Timing
- Grant latency: 0 cycles (gnt is in the same cycle as the req).
- Command latency: cmd_valid and the cmd_* fields appear 1 cycle after the grant. With no grant, cmd_valid=0 and cmd_type=NOP the next cycle.
- Constraint spacing: with t_x_m1 = N, the earliest following constrained command is granted N+1 cycles after the first.
- Reset values:
  - cmd_valid=0, cmd_type=NOP, all cmd_* fields 0.
  - All counters 0 and rr_ptr=0.
  - All gnt outputs are forced to 0 while rst is high.
- Reset mid-operation: pending timers are cleared and the next grant is allowed on the first cycle after rst deasserts. Bank controllers are reset by the same rst.
- Simultaneous events: a grant in a cycle where a counter reaches 0 is legal only if the counter was already 0 at the start of that cycle. Eligibility uses registered counter values.

## Configuration
- SAL_SCHED_CAS_FIRST_EN defined: two-level arbitration.
  - If any bank has an eligible RD/WR candidate, round-robin runs only over CAS candidates.
  - Otherwise it runs over the remaining candidates.
  - REF still outranks everything (checked first).
- Undefined: a single round-robin over all eligible candidates regardless of command class.

## Structure
- Shared package sal_sched_pkg holds:
  - sched_cmd_t enum: NOP=0, ACT, RD, WR, PRE, REF.
  - Command-priority constants.
- Sub-module sal_rr_arbiter (parameter N) implements the one-hot rotating-priority pick from req[N] and ptr. It is instantiated once, or twice when SAL_SCHED_CAS_FIRST_EN is defined.

## Test plan
- Reset: hold rst 3 cycles while all reqs are 1. Expect all gnt=0 and cmd_valid=0; the first grant goes to bank 0 on the cycle after rst falls.
- tRRD: t_rrd_m1=3, banks 0 and 1 request ACT at cycle 0. Expect bank0 ACT gnt at cycle 0, bank1 ACT gnt at cycle 4, and cmd ACT outputs at cycles 1 and 5.
- WR→RD: t_wtr_m1=5, t_ccd_m1=1. Bank2 WR at cycle 0, bank3 RD pending. Expect RD gnt at cycle 6, not earlier.
- RD→WR with PRE fill: t_rtw_m1=2, bank0 RD at cycle 0, bank1 WR and bank2 PRE pending. Expect PRE granted at cycle 1 and WR at cycle 3.
- Fairness: all 4 banks hold PRE continuously. Expect grants in order 0,1,2,3,0 on consecutive cycles.
- With SAL_SCHED_CAS_FIRST_EN: bank0 ACT and bank1 RD at cycle 0, rr_ptr=0. Expect bank1 RD first, then bank0 ACT. Without the macro, expect bank0 ACT first.
